// File: rtl/array_writer_if.sv
// Command channel of the heap-array write engine: handshake, operands and completion status.
interface array_writer_if #(
  parameter int MemoryElementWidth = 12
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [1:0]                    cmd_op;
  logic [MemoryElementWidth-1:0] cmd_array;
  logic [MemoryElementWidth-1:0] cmd_index;
  logic [MemoryElementWidth-1:0] cmd_value;
  logic                          done;
  logic                          error;

  modport master (
    output cmd_valid, cmd_op, cmd_array, cmd_index, cmd_value,
    input  cmd_ready, done, error
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_array, cmd_index, cmd_value,
    output cmd_ready, done, error
  );
endinterface

// File: rtl/array_writer.sv
// Write-side engine for heap arrays: push, insert-at-index, remove-at-index and clear, one element move per cycle.
// Optional macro ARRAY_WRITER_SATURATE_EN: insert into a full array drops the top element instead of erroring.
module array_writer #(
  parameter int MemoryElementWidth = 12,
  parameter int NArea              = 4,
  parameter int NArrays            = 20
) (
  input  logic                          clock,
  input  logic                          reset,
  array_writer_if.slave                 cmdBus,
  input  logic [MemoryElementWidth-1:0] rd_array,
  input  logic [MemoryElementWidth-1:0] rd_index,
  output logic [MemoryElementWidth-1:0] rd_data,
  output logic [MemoryElementWidth-1:0] rd_size
);
  localparam int MEW = MemoryElementWidth;
  localparam int AW  = (NArrays > 1) ? $clog2(NArrays) : 1;
  localparam int EW  = $clog2(NArea);
  localparam int SW  = $clog2(NArea + 1);

  typedef enum logic [1:0] {IDLE, SHIFT_UP, SHIFT_DOWN, FINISH} stateT;
  typedef enum logic [1:0] {OP_PUSH, OP_INSERT, OP_REMOVE, OP_CLEAR} opT;

  logic [MEW-1:0] heap  [NArrays][NArea];
  logic [SW-1:0]  sizes [NArrays];

  stateT          state;
  logic           cmdReadyR;
  logic           doneR;
  logic           errorR;
  logic [AW-1:0]  arrayR;
  logic [EW-1:0]  indexR;
  logic [MEW-1:0] valueR;
  logic [SW-1:0]  sizeR;
  logic [EW-1:0]  ptr;

  logic           arrayOk;
  logic [AW-1:0]  cmdArrIdx;
  logic [SW-1:0]  curSize;
  logic [MEW-1:0] sizeExt;
  logic           full;
  logic           pushErr;
  logic           insertErr;
  logic           removeErr;

  logic           rdArrayOk;
  logic           rdIndexOk;
  logic [AW-1:0]  rdArrIdx;

  assign cmdBus.cmd_ready = cmdReadyR;
  assign cmdBus.done      = doneR;
  assign cmdBus.error     = errorR;

  // Decode of the offered command against the current size of its target array.
  always_comb begin
    arrayOk   = cmdBus.cmd_array < MEW'(NArrays);
    cmdArrIdx = cmdBus.cmd_array[AW-1:0];
    curSize   = arrayOk ? sizes[cmdArrIdx] : '0;
    sizeExt   = MEW'(curSize);
    full      = (curSize == SW'(NArea));
    pushErr   = !arrayOk || full;
`ifdef ARRAY_WRITER_SATURATE_EN
    insertErr = !arrayOk || (cmdBus.cmd_index > sizeExt) ||
                (full && (cmdBus.cmd_index >= MEW'(NArea)));
`else
    insertErr = !arrayOk || (cmdBus.cmd_index > sizeExt) || full;
`endif
    removeErr = !arrayOk || (cmdBus.cmd_index >= sizeExt);
  end

  // Read port shows committed storage; out-of-range selects read as zero.
  always_comb begin
    rdArrayOk = rd_array < MEW'(NArrays);
    rdIndexOk = rd_index < MEW'(NArea);
    rdArrIdx  = rd_array[AW-1:0];
    rd_data   = (rdArrayOk && rdIndexOk) ? heap[rdArrIdx][rd_index[EW-1:0]] : '0;
    rd_size   = rdArrayOk ? MEW'(sizes[rdArrIdx]) : '0;
  end

  // Command FSM; element storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cmdReadyR <= 1'b1;
      doneR     <= 1'b0;
      errorR    <= 1'b0;
      arrayR    <= '0;
      indexR    <= '0;
      valueR    <= '0;
      sizeR     <= '0;
      ptr       <= '0;
      for (int i = 0; i < NArrays; i++) sizes[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmdBus.cmd_valid) begin
            cmdReadyR <= 1'b0;
            arrayR    <= cmdArrIdx;
            indexR    <= cmdBus.cmd_index[EW-1:0];
            valueR    <= cmdBus.cmd_value;
            sizeR     <= curSize;
            case (cmdBus.cmd_op)
              OP_PUSH: begin
                state <= FINISH;
                doneR <= 1'b1;
                if (pushErr) begin
                  errorR <= 1'b1;
                end else begin
                  errorR <= 1'b0;
                  heap[cmdArrIdx][curSize[EW-1:0]] <= cmdBus.cmd_value;
                  sizes[cmdArrIdx] <= curSize + SW'(1);
                end
              end
              OP_INSERT: begin
                if (insertErr) begin
                  state  <= FINISH;
                  doneR  <= 1'b1;
                  errorR <= 1'b1;
                end else begin
                  // A full array (saturating build only) starts at the top slot, discarding it.
                  ptr   <= full ? EW'(NArea - 1) : curSize[EW-1:0];
                  state <= SHIFT_UP;
                end
              end
              OP_REMOVE: begin
                if (removeErr) begin
                  state  <= FINISH;
                  doneR  <= 1'b1;
                  errorR <= 1'b1;
                end else begin
                  ptr   <= cmdBus.cmd_index[EW-1:0];
                  state <= SHIFT_DOWN;
                end
              end
              OP_CLEAR: begin
                state  <= FINISH;
                doneR  <= 1'b1;
                errorR <= !arrayOk;
                if (arrayOk) sizes[cmdArrIdx] <= '0;
              end
            endcase
          end
        end
        SHIFT_UP: begin
          if (ptr == indexR) begin
            heap[arrayR][ptr] <= valueR;
            sizes[arrayR]     <= (sizeR == SW'(NArea)) ? sizeR : sizeR + SW'(1);
            state             <= FINISH;
            doneR             <= 1'b1;
            errorR            <= 1'b0;
          end else begin
            heap[arrayR][ptr] <= heap[arrayR][ptr - EW'(1)];
            ptr               <= ptr - EW'(1);
          end
        end
        SHIFT_DOWN: begin
          if (SW'(ptr) + SW'(1) == sizeR) begin
            sizes[arrayR] <= sizeR - SW'(1);
            state         <= FINISH;
            doneR         <= 1'b1;
            errorR        <= 1'b0;
          end else begin
            heap[arrayR][ptr] <= heap[arrayR][ptr + EW'(1)];
            ptr               <= ptr + EW'(1);
          end
        end
        FINISH: begin
          doneR     <= 1'b0;
          errorR    <= 1'b0;
          cmdReadyR <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_array_writer.sv
// Scoreboard bench for array_writer: queue-based reference model, directed cases then random commands.
module tb_array_writer;
  localparam int MEW   = 12;
  localparam int NAREA = 4;
  localparam int NARR  = 20;

  typedef struct {
    bit err;
    int lat;
  } expT;

  logic           clock = 1'b0;
  logic           reset;
  logic [MEW-1:0] rdArray;
  logic [MEW-1:0] rdIndex;
  logic [MEW-1:0] rdData;
  logic [MEW-1:0] rdSize;

  int checks      = 0;
  int failures    = 0;
  int cycleCount  = 0;
  int acceptCycle = 0;

  int unsigned mdlData [NARR][NAREA];
  int          mdlSize [NARR];
  expT         sbq [$];

  array_writer_if #(.MemoryElementWidth(MEW)) cmdBus ();

  array_writer #(
    .MemoryElementWidth(MEW),
    .NArea(NAREA),
    .NArrays(NARR)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmdBus(cmdBus),
    .rd_array(rdArray),
    .rd_index(rdIndex),
    .rd_data(rdData),
    .rd_size(rdSize)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycleCount <= cycleCount + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Reference behaviour expressed as list operations on a queue per array.
  task automatic modelApply(input int op, input int arr, input int idx, input int unsigned val,
                            output bit err, output int lat);
    int unsigned q [$];
    err = 1'b0;
    lat = 1;
    if (arr >= NARR) begin
      err = 1'b1;
      return;
    end
    for (int i = 0; i < mdlSize[arr]; i++) q.push_back(mdlData[arr][i]);
    case (op)
      0: if (q.size() == NAREA) err = 1'b1; else q.push_back(val);
      1: begin
        if (idx > q.size()) err = 1'b1;
        else if (q.size() == NAREA) begin
`ifdef ARRAY_WRITER_SATURATE_EN
          if (idx >= NAREA) err = 1'b1;
          else begin
            void'(q.pop_back());
            q.insert(idx, val);
            lat = (NAREA - 1) - idx + 2;
          end
`else
          err = 1'b1;
`endif
        end else begin
          lat = q.size() - idx + 2;
          q.insert(idx, val);
        end
      end
      2: begin
        if (idx >= q.size()) err = 1'b1;
        else begin
          lat = q.size() - idx + 1;
          q.delete(idx);
        end
      end
      default: q.delete();
    endcase
    mdlSize[arr] = q.size();
    for (int i = 0; i < q.size(); i++) mdlData[arr][i] = q[i];
  endtask

  task automatic checkArray(input int arr);
    rdArray = MEW'(arr);
    for (int i = 0; i < NAREA; i++) begin
      rdIndex = MEW'(i);
      #1;
      if (arr < NARR && i < mdlSize[arr])
        checkOutput($sformatf("rd_data[%0d][%0d]", arr, i), int'(rdData), int'(mdlData[arr][i]));
    end
    checkOutput($sformatf("rd_size[%0d]", arr), int'(rdSize), (arr < NARR) ? mdlSize[arr] : 0);
  endtask

  task automatic waitDone();
    int guard = 0;
    while (sbq.size() != 0 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no done in %0d cycles, required a done pulse", guard);
      sbq.delete();
    end
  endtask

  task automatic applyStimulus(input int op, input int arr, input int idx, input int unsigned val);
    int  guard = 0;
    expT e;
    @(negedge clock);
    cmdBus.cmd_op    = 2'(op);
    cmdBus.cmd_array = MEW'(arr);
    cmdBus.cmd_index = MEW'(idx);
    cmdBus.cmd_value = MEW'(val);
    cmdBus.cmd_valid = 1'b1;
    while (cmdBus.cmd_ready !== 1'b1 && guard < 40) begin
      @(negedge clock);
      guard++;
    end
    if (cmdBus.cmd_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL ready_timeout: got cmd_ready=%b, required 1", cmdBus.cmd_ready);
      cmdBus.cmd_valid = 1'b0;
      return;
    end
    modelApply(op, arr, idx, val, e.err, e.lat);
    sbq.push_back(e);
    @(posedge clock);
    #1 acceptCycle = cycleCount;
    @(negedge clock);
    cmdBus.cmd_valid = 1'b0;
    waitDone();
    checkArray(arr);
  endtask

  // Monitor: every done pulse is matched against the oldest outstanding expectation.
  initial begin
    expT e;
    forever begin
      @(negedge clock);
      if (cmdBus.done === 1'b1) begin
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_done: got done=1, required 0 with no command pending");
        end else begin
          e = sbq.pop_front();
          checkOutput("done_error", int'(cmdBus.error), int'(e.err));
          checkOutput("latency", cycleCount - acceptCycle + 1, e.lat);
        end
      end
    end
  end

  initial begin
    int r;
    int arr;
    int op;
    cmdBus.cmd_valid = 1'b0;
    cmdBus.cmd_op    = '0;
    cmdBus.cmd_array = '0;
    cmdBus.cmd_index = '0;
    cmdBus.cmd_value = '0;
    rdArray = '0;
    rdIndex = '0;
    for (int a = 0; a < NARR; a++) mdlSize[a] = 0;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checkOutput("reset_ready", int'(cmdBus.cmd_ready), 1);
    checkOutput("reset_done", int'(cmdBus.done), 0);
    checkOutput("reset_error", int'(cmdBus.error), 0);
    checkArray(0);

    applyStimulus(0, 0, 0, 10);
    applyStimulus(0, 0, 0, 20);
    applyStimulus(0, 0, 0, 30);
    applyStimulus(1, 0, 1, 15);
    applyStimulus(2, 0, 0, 0);
    applyStimulus(0, 0, 0, 40);
    applyStimulus(0, 0, 0, 50);
    applyStimulus(1, 0, 0, 7);
    for (int v = 1; v <= 3; v++) applyStimulus(0, 2, 0, v * 100);
    applyStimulus(1, 2, 5, 1);
    applyStimulus(1, 2, 3, 333);
    applyStimulus(2, 2, 3, 0);
    applyStimulus(0, NARR, 0, 1);
    applyStimulus(3, NARR + 1, 0, 0);
    for (int v = 1; v <= 4; v++) applyStimulus(0, 3, 0, v * 10);
    applyStimulus(1, 3, 0, 5);
    applyStimulus(1, 3, 3, 77);

    @(negedge clock);
    rdArray = '0;
    rdIndex = MEW'(NAREA);
    #1 checkOutput("rd_data_index_oor", int'(rdData), 0);
    rdArray = MEW'(NARR);
    rdIndex = '0;
    #1 checkOutput("rd_data_array_oor", int'(rdData), 0);
    checkOutput("rd_size_array_oor", int'(rdSize), 0);

    // Reset lands in the second SHIFT_UP cycle of an insert at index 0 of a 3-element array.
    @(negedge clock);
    cmdBus.cmd_op    = 2'd1;
    cmdBus.cmd_array = MEW'(2);
    cmdBus.cmd_index = '0;
    cmdBus.cmd_value = MEW'(99);
    cmdBus.cmd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmdBus.cmd_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int a = 0; a < NARR; a++) mdlSize[a] = 0;
    checkOutput("midop_ready", int'(cmdBus.cmd_ready), 1);
    checkOutput("midop_done", int'(cmdBus.done), 0);
    checkArray(2);
    checkArray(0);
    repeat (4) @(negedge clock);

    for (int n = 0; n < 200; n++) begin
      r   = $urandom_range(0, 9);
      arr = (r < 8) ? (r % 4) : (NARR + r - 8);
      r   = $urandom_range(0, 9);
      op  = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
      applyStimulus(op, arr, $urandom_range(0, 5), $urandom_range(0, (1 << MEW) - 1));
    end

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
